// File: rtl/vga_pkg.sv
// Shared timing constants, card/colour types and the symbol palette for the
// memory-game VGA renderer.
package vga_pkg;
    localparam int H_VIS  = 640;
    localparam int H_FP   = 16;
    localparam int H_SYNC = 96;
    localparam int H_BP   = 48;
    localparam int V_VIS  = 480;
    localparam int V_FP   = 10;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 33;
    localparam int CELL   = 120;
    localparam int BORDER = 4;

    typedef enum logic [1:0] {RG_BLANK, RG_LEFT, RG_RIGHT, RG_CELL} region_e;

    typedef struct packed {
        logic       up;
        logic [2:0] sym;
    } card_code_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK  = 24'h000000;
    localparam rgb_t C_GREEN  = 24'h00ff00;
    localparam rgb_t C_BLUE   = 24'h0000ff;
    localparam rgb_t C_YELLOW = 24'hffff00;
    localparam rgb_t C_WHITE  = 24'hffffff;
    localparam rgb_t C_GRAY   = 24'h404040;

    localparam rgb_t PALETTE [8] = '{
        24'hff0000, 24'h00ff00, 24'h00ffff, 24'hff00ff,
        24'hff8000, 24'h8000ff, 24'hff80c0, 24'hffffff
    };
endpackage

// File: rtl/vga_timing.sv
// Pixel-enable, pixel clock and raster counters; sync/visible flags are
// decoded combinationally from the current counter values.
module vga_timing #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pe,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       visible,
    output logic       vgaclk
);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);

    logic       pe_q, pe_d;
    logic       vgaclk_q, vgaclk_d;
    logic [9:0] hcnt_q, hcnt_d;
    logic [9:0] vcnt_q, vcnt_d;

    always_comb begin
        pe_d     = ~pe_q;
        // Rises one clk after the pixel registers update: mid-way through the stable window.
        vgaclk_d = ~pe_q;
        hcnt_d   = hcnt_q;
        vcnt_d   = vcnt_q;
        if (pe_q) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = '0;
                vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
            end else begin
                hcnt_d = hcnt_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_q     <= 1'b0;
            vgaclk_q <= 1'b0;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
        end else begin
            pe_q     <= pe_d;
            vgaclk_q <= vgaclk_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
        end
    end

    assign pe        = pe_q;
    assign vgaclk    = vgaclk_q;
    assign hcnt      = hcnt_q;
    assign vcnt      = vcnt_q;
    assign hsync_raw = !(hcnt_q >= HS_START && hcnt_q < HS_END);
    assign vsync_raw = !(vcnt_q >= VS_START && vcnt_q < VS_END);
    assign visible   = (hcnt_q < H_VIS_C) && (vcnt_q < V_VIS_C);
endmodule

// File: rtl/vga_board_render.sv
// Draws the 4x4 card board, cursor highlight and turn margins; card state is
// latched once per frame at the start of vertical blanking.
module vga_board_render #(
    parameter int H_VIS  = vga_pkg::H_VIS,
    parameter int H_FP   = vga_pkg::H_FP,
    parameter int H_SYNC = vga_pkg::H_SYNC,
    parameter int H_BP   = vga_pkg::H_BP,
    parameter int V_VIS  = vga_pkg::V_VIS,
    parameter int V_FP   = vga_pkg::V_FP,
    parameter int V_SYNC = vga_pkg::V_SYNC,
    parameter int V_BP   = vga_pkg::V_BP,
    parameter int CELL   = vga_pkg::CELL,
    parameter int BORDER = vga_pkg::BORDER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] cards,
    input  logic [15:0] matched,
    input  logic [3:0]  cursor,
    input  logic        player,
    output logic [7:0]  R,
    output logic [7:0]  G,
    output logic [7:0]  B,
    output logic        hsync,
    output logic        vsync,
    output logic        vgaclk
);
    import vga_pkg::*;

    localparam int MARGIN = (H_VIS - 4 * CELL) / 2;
    localparam logic [9:0] X0 = 10'(MARGIN);
    localparam logic [9:0] X1 = 10'(MARGIN + CELL);
    localparam logic [9:0] X2 = 10'(MARGIN + 2 * CELL);
    localparam logic [9:0] X3 = 10'(MARGIN + 3 * CELL);
    localparam logic [9:0] X4 = 10'(MARGIN + 4 * CELL);
    localparam logic [9:0] Y1 = 10'(CELL);
    localparam logic [9:0] Y2 = 10'(2 * CELL);
    localparam logic [9:0] Y3 = 10'(3 * CELL);
    localparam logic [9:0] B_LO = 10'(BORDER);
    localparam logic [9:0] B_HI = 10'(CELL - BORDER);
    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LASTVIS = 10'(V_VIS - 1);

    logic       pe, hsync_raw, vsync_raw, visible;
    logic [9:0] hcnt, vcnt;

    vga_timing #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk(clk), .rst_n(rst_n), .pe(pe), .hcnt(hcnt), .vcnt(vcnt),
        .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .visible(visible),
        .vgaclk(vgaclk)
    );

    logic [63:0] cards_f_q, cards_f_d;
    logic [15:0] matched_f_q, matched_f_d;
    logic [3:0]  cursor_f_q, cursor_f_d;
    logic        player_f_q, player_f_d;

    always_comb begin
        cards_f_d   = cards_f_q;
        matched_f_d = matched_f_q;
        cursor_f_d  = cursor_f_q;
        player_f_d  = player_f_q;
        if (pe && hcnt == H_LAST && vcnt == V_LASTVIS) begin
            cards_f_d   = cards;
            matched_f_d = matched;
            cursor_f_d  = cursor;
            player_f_d  = player;
        end
    end

    // Stage 1: region, card index and border flag from the raster position
    region_e    region_p1_q, region_p1_d;
    logic [3:0] idx_p1_q, idx_p1_d;
    logic       border_p1_q, border_p1_d;
    logic       hsync_p1_q, hsync_p1_d;
    logic       vsync_p1_q, vsync_p1_d;
    logic [1:0] col, row;
    logic [9:0] x_base, y_base, lx, ly;

    always_comb begin
        col    = 2'd3;
        x_base = X3;
        if (hcnt < X1)      begin col = 2'd0; x_base = X0; end
        else if (hcnt < X2) begin col = 2'd1; x_base = X1; end
        else if (hcnt < X3) begin col = 2'd2; x_base = X2; end
        row    = 2'd3;
        y_base = Y3;
        if (vcnt < Y1)      begin row = 2'd0; y_base = '0; end
        else if (vcnt < Y2) begin row = 2'd1; y_base = Y1; end
        else if (vcnt < Y3) begin row = 2'd2; y_base = Y2; end
        lx = hcnt - x_base;
        ly = vcnt - y_base;

        region_p1_d = region_p1_q;
        idx_p1_d    = idx_p1_q;
        border_p1_d = border_p1_q;
        hsync_p1_d  = hsync_p1_q;
        vsync_p1_d  = vsync_p1_q;
        if (pe) begin
            idx_p1_d    = {row, col};
            border_p1_d = (lx < B_LO) || (lx >= B_HI) || (ly < B_LO) || (ly >= B_HI);
            hsync_p1_d  = hsync_raw;
            vsync_p1_d  = vsync_raw;
            if (!visible)        region_p1_d = RG_BLANK;
            else if (hcnt < X0)  region_p1_d = RG_LEFT;
            else if (hcnt >= X4) region_p1_d = RG_RIGHT;
            else                 region_p1_d = RG_CELL;
        end
    end

    // Stage 2: colour lookup against the frame snapshot
    rgb_t       rgb_p2_q, rgb_p2_d;
    logic       hsync_p2_q, hsync_p2_d;
    logic       vsync_p2_q, vsync_p2_d;
    card_code_t card;
    rgb_t       pix;

    always_comb begin
        card = cards_f_q[{idx_p1_q, 2'b00} +: 4];
        pix  = C_BLACK;
        case (region_p1_q)
            RG_LEFT:  pix = player_f_q ? C_BLACK : C_GREEN;
            RG_RIGHT: pix = player_f_q ? C_GREEN : C_BLACK;
            RG_CELL: begin
                if (border_p1_q)              pix = (idx_p1_q == cursor_f_q) ? C_YELLOW : C_WHITE;
                else if (matched_f_q[idx_p1_q]) pix = C_GRAY;
                else if (card.up)             pix = PALETTE[card.sym];
                else                          pix = C_BLUE;
            end
            default:  pix = C_BLACK;
        endcase

        rgb_p2_d   = rgb_p2_q;
        hsync_p2_d = hsync_p2_q;
        vsync_p2_d = vsync_p2_q;
        if (pe) begin
            rgb_p2_d   = pix;
            hsync_p2_d = hsync_p1_q;
            vsync_p2_d = vsync_p1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cards_f_q   <= '0;
            matched_f_q <= '0;
            cursor_f_q  <= '0;
            player_f_q  <= 1'b0;
            region_p1_q <= RG_BLANK;
            idx_p1_q    <= '0;
            border_p1_q <= 1'b0;
            hsync_p1_q  <= 1'b1;
            vsync_p1_q  <= 1'b1;
            rgb_p2_q    <= C_BLACK;
            hsync_p2_q  <= 1'b1;
            vsync_p2_q  <= 1'b1;
        end else begin
            cards_f_q   <= cards_f_d;
            matched_f_q <= matched_f_d;
            cursor_f_q  <= cursor_f_d;
            player_f_q  <= player_f_d;
            region_p1_q <= region_p1_d;
            idx_p1_q    <= idx_p1_d;
            border_p1_q <= border_p1_d;
            hsync_p1_q  <= hsync_p1_d;
            vsync_p1_q  <= vsync_p1_d;
            rgb_p2_q    <= rgb_p2_d;
            hsync_p2_q  <= hsync_p2_d;
            vsync_p2_q  <= vsync_p2_d;
        end
    end

    assign R     = rgb_p2_q.r;
    assign G     = rgb_p2_q.g;
    assign B     = rgb_p2_q.b;
    assign hsync = hsync_p2_q;
    assign vsync = vsync_p2_q;
endmodule
